ext_dut_arbiter: RTL and testbench
==================================

// Module: ext_dut_arbiter
// PURPOSE
//   Shares one ParameterizedExtModule-style datapath instance (foo in, bar out) among NREQ requesters.
//   Each requester offers a narrow unsigned operand. The block:
//   - picks a requester round-robin;
//   - zero-pads the operand to DUT_W and drives it on foo;
//   - waits the fixed datapath latency, captures bar, and returns it tagged with the requester id.
//   One transaction is in flight at a time. The block sits between tester/stimulus logic and the shared ext instance.
// PARAMETERS
//   NREQ     4   number of requesters, >=2
//   IN_W     10  requester operand width; must be <= DUT_W (elaboration error otherwise)
//   DUT_W    16  width of ext module foo/bar ports
//   LATENCY  2   cycles from a foo change to a valid bar, >=1
//   IDW      $clog2(NREQ)  width of the response id
// PORTS
//   clock       in   1           single clock, rising edge
//   reset       in   1           asynchronous, active-low reset
//   req_valid   in   NREQ        per-requester request
//   req_data    in   NREQ*IN_W   operands; slice i belongs to requester i
//   req_ready   out  NREQ        one-hot grant/accept, only in IDLE
//   dut_foo     out  DUT_W       registered, zero-padded operand to the ext instance
//   dut_bar     in   DUT_W       ext instance result
//   resp_valid  out  1           result available
//   resp_ready  in   1           consumer accepts result
//   resp_data   out  DUT_W       captured bar
//   resp_id     out  IDW         index of the requester that owns resp_data
//   busy        out  1           state != IDLE
// BEHAVIOUR
//   Reset (reset==0, async):
//   - state=IDLE, rr pointer=0, counter=0.
//   - dut_foo, resp_data, resp_id, resp_valid, busy, req_ready all 0.
//   - Any in-flight transaction is discarded; no response is ever issued for it.
//   FSM IDLE -> WAIT -> RESP -> IDLE:
//   - IDLE: if |req_valid, grant g = the first valid index searching ptr, ptr+1, ... mod NREQ.
//     - req_ready = onehot(g), combinational, same cycle; handshake = req_valid[g] & req_ready[g].
//     - On handshake: dut_foo <= {zeros, req_data[g]}; id <= g; counter <= LATENCY-1; ptr <= (g+1) mod NREQ; -> WAIT.
//   - WAIT: req_ready=0.
//     - counter!=0: decrement.
//     - counter==0: resp_data <= dut_bar; resp_valid <= 1; -> RESP.
//   - RESP: resp_valid, resp_data and resp_id are held stable until resp_ready.
//     - On resp_valid & resp_ready: resp_valid <= 0; -> IDLE.
//     - No new grant in the same cycle; the next grant comes no earlier than the following cycle.
//   Timing:
//   - Handshake in cycle T -> dut_foo valid from T+1 -> bar sampled at the end of cycle T+LATENCY -> resp_valid from cycle T+LATENCY+1.
//   - Best-case throughput: one transaction per LATENCY+2 cycles.
//   Boundaries:
//   - req_valid deasserting while in WAIT or RESP has no effect.
//   - req_data changes after the handshake are ignored.
//   - dut_foo holds its last operand while IDLE.
//   - ptr wraps NREQ-1 -> 0.
//   - A lone requester is granted back-to-back.
//   - resp_ready held high permanently: RESP lasts exactly 1 cycle.
//   Width: operand is zero-extended only (unsigned); no truncation path exists.
// STRUCTURE
//   - Package ext_dut_arb_pkg: state_t enum {IDLE, WAIT, RESP}, default DUT_W/IN_W localparams, pad helper function.
//   - Sub-module rr_arbiter #(N): inputs req[N] and ptr; outputs onehot grant and grant index.
//     - Combinational; the pointer register stays in ext_dut_arbiter.
//   - The ext instance itself lives outside; this block only drives foo and samples bar.
// TESTING
//   Bench: ext model with bar = foo ^ 16'hFFFF, delayed LATENCY-1 register stages after foo.
//   Directed scenarios:
//   1. LATENCY=2, req_valid=4'b0001, data0=10'h3E8, resp_ready=1, handshake in cycle 0
//      -> dut_foo=16'h03E8 in cycle 1; resp_valid in cycle 3; resp_data=16'hFC17; resp_id=0.
//   2. req_valid=4'b1111 held, resp_ready=1 -> grant order 0,1,2,3,0 -> resp_id sequence 0,1,2,3,0; new grant every 4 cycles.
//   3. ptr=3, req_valid=4'b0101 -> grant 0 (wrap), then 2.
//   4. resp_ready=0 for 5 cycles in RESP -> resp_valid, resp_data and resp_id stable; req_ready=0 throughout; release -> IDLE next cycle.
//   5. reset asserted in WAIT
//      -> outputs 0 immediately (async); no resp_valid after release; first grant after release is 0.
//   6. data=10'h000 and 10'h3FF -> dut_foo = 16'h0000 and 16'h03FF; upper 6 bits always 0.

Source files
------------

// File: rtl/ext_dut_arb_pkg.sv
// Shared types and helpers for the ext datapath arbiter: FSM state encoding,
// default port widths and the operand zero-padding function.
package ext_dut_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEF_IN_W  = 10;
  localparam int DEF_DUT_W = 16;
  localparam int PAD_W     = 64;

  // Keeps only the low op_w bits; callers widen/narrow around the fixed PAD_W.
  function automatic logic [PAD_W-1:0] pad_operand(input logic [PAD_W-1:0] op,
                                                   input int unsigned      op_w);
    logic [PAD_W-1:0] mask;
    mask = (op_w >= unsigned'(PAD_W)) ? {PAD_W{1'b1}}
                                      : ((PAD_W'(1'b1) << op_w) - PAD_W'(1'b1));
    return op & mask;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping modulo N. The pointer register is owned by the caller.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] cand_s;
  logic          hit_s;
  logic          found_s;

  // Walk ptr, ptr+1, ... and latch the first hit.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand_s    = '0;
    hit_s     = 1'b0;
    found_s   = 1'b0;
    for (int k = 0; k < N; k++) begin
      cand_s        = IW'((int'(ptr) + k) % N);
      hit_s         = req[cand_s] & ~found_s;
      grant[cand_s] = grant[cand_s] | hit_s;
      grant_idx     = hit_s ? cand_s : grant_idx;
      found_s       = found_s | hit_s;
    end
  end

endmodule

// File: rtl/ext_dut_arbiter.sv
// Time-shares one external foo->bar datapath among NREQ requesters, one
// transaction at a time, returning each captured result tagged with its owner.
module ext_dut_arbiter
  import ext_dut_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int IN_W    = DEF_IN_W,
  parameter int DUT_W   = DEF_DUT_W,
  parameter int LATENCY = 2,
  parameter int IDW     = $clog2(NREQ)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*IN_W-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic [DUT_W-1:0]     dut_foo,
  input  logic [DUT_W-1:0]     dut_bar,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [DUT_W-1:0]     resp_data,
  output logic [IDW-1:0]       resp_id,
  output logic                 busy
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  if (IN_W > DUT_W || DUT_W > PAD_W || NREQ < 2 || LATENCY < 1) begin : g_bad_params
    $error("ext_dut_arbiter: illegal parameters (need IN_W<=DUT_W<=PAD_W, NREQ>=2, LATENCY>=1)");
  end

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DUT_W-1:0] foo_q, foo_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [DUT_W-1:0] rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;

  logic [NREQ-1:0]  gnt_s;
  logic [IDW-1:0]   gnt_idx_s;
  logic [IN_W-1:0]  operand_s;
  logic             hs_s;

  rr_arbiter #(.N(NREQ), .IW(IDW)) u_rr (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (gnt_s),
    .grant_idx (gnt_idx_s)
  );

  assign operand_s = req_data[int'(gnt_idx_s)*IN_W +: IN_W];
  assign hs_s      = |(req_valid & gnt_s);

  // Next-state, datapath loads and the combinational grant.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    foo_d     = foo_q;
    id_d      = id_q;
    rdata_d   = rdata_q;
    rvalid_d  = rvalid_q;
    req_ready = '0;
    case (state_q)
      IDLE: begin
        // Grant is masked while reset is held so nothing looks accepted.
        req_ready = gnt_s & {NREQ{reset}};
        if (hs_s) begin
          foo_d   = DUT_W'(pad_operand(PAD_W'(operand_s), unsigned'(IN_W)));
          id_d    = gnt_idx_s;
          cnt_d   = CNT_W'(LATENCY - 1);
          ptr_d   = (gnt_idx_s == IDW'(NREQ - 1)) ? '0 : gnt_idx_s + IDW'(1'b1);
          state_d = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1'b1);
        end else begin
          rdata_d  = dut_bar;
          rvalid_d = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          rvalid_d = 1'b0;
          state_d  = IDLE;
        end else begin
          state_d  = RESP;
        end
      end
      default: begin
        rvalid_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any in-flight transaction.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      foo_q    <= '0;
      id_q     <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      foo_q    <= foo_d;
      id_q     <= id_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign dut_foo    = foo_q;
  assign resp_valid = rvalid_q;
  assign resp_data  = rdata_q;
  assign resp_id    = id_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ext_dut_arbiter.sv
// Self-checking bench for ext_dut_arbiter: an ext model (bar = foo ^ 16'hFFFF,
// LATENCY-1 stages) plus a transaction-level round-robin reference model.
module tb_ext_dut_arbiter;

  localparam int NREQ    = 4;
  localparam int IN_W    = 10;
  localparam int DUT_W   = 16;
  localparam int LATENCY = 2;
  localparam int IDW     = 2;
  localparam int DW      = NREQ * IN_W;

  logic             clock;
  logic             reset;
  logic [NREQ-1:0]  req_valid;
  logic [DW-1:0]    req_data;
  logic [NREQ-1:0]  req_ready;
  logic [DUT_W-1:0] dut_foo;
  logic [DUT_W-1:0] dut_bar;
  logic             resp_valid;
  logic             resp_ready;
  logic [DUT_W-1:0] resp_data;
  logic [IDW-1:0]   resp_id;
  logic             busy;

  int tests_run;
  int tests_failed;
  int m_ptr;

  ext_dut_arbiter #(.NREQ(NREQ), .IN_W(IN_W), .DUT_W(DUT_W), .LATENCY(LATENCY), .IDW(IDW)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .dut_foo    (dut_foo),
    .dut_bar    (dut_bar),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // External datapath model
  logic [DUT_W-1:0] pipe [0:LATENCY-2];
  always @(posedge clock) begin
    pipe[0] <= dut_foo;
    for (int i = 1; i < LATENCY - 1; i++) pipe[i] <= pipe[i-1];
  end
  assign dut_bar = pipe[LATENCY-2] ^ 16'hFFFF;

  function automatic int model_grant(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++)
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  function automatic int unsigned model_operand(input logic [DW-1:0] d, input int g);
    logic [DW-1:0] sh;
    sh = d >> (g * IN_W);
    return int'(sh % DW'(1 << IN_W));
  endfunction

  function automatic logic [NREQ-1:0] model_onehot(input int g);
    logic [NREQ-1:0] oh;
    oh = '0;
    if (g >= 0) oh[g] = 1'b1;
    return oh;
  endfunction

  // One transaction from IDLE: returns what was observed; callers compare.
  task automatic txn(input logic [NREQ-1:0] v, input logic [DW-1:0] d, input int hold,
                     output logic [NREQ-1:0] rdy, output logic [DUT_W-1:0] foo, output int lat,
                     output logic [DUT_W-1:0] rdata, output logic [IDW-1:0] rid,
                     output bit stable, output bit idle_after);
    int n;
    @(negedge clock);
    req_valid  = v;
    req_data   = d;
    resp_ready = 1'b0;
    #1 rdy = req_ready;
    @(posedge clock);
    #1;
    req_valid = NREQ'($urandom_range(1, (1 << NREQ) - 1));
    req_data  = DW'({$urandom(), $urandom()});
    n = 0; lat = -1; foo = '0; stable = 1'b1;
    while (lat < 0 && n < 20) begin
      @(negedge clock);
      n++;
      if (n == 1) foo = dut_foo;
      if (req_ready !== '0) stable = 1'b0;
      if (resp_valid === 1'b1) lat = n;
    end
    rdata = resp_data;
    rid   = resp_id;
    for (int k = 0; k < hold; k++) begin
      @(negedge clock);
      if (resp_valid !== 1'b1 || resp_data !== rdata || resp_id !== rid || req_ready !== '0)
        stable = 1'b0;
    end
    resp_ready = 1'b1;
    req_valid  = '0;
    @(negedge clock);
    idle_after = (busy === 1'b0) && (resp_valid === 1'b0);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset      = 1'b0;
    req_valid  = '1;
    req_data   = DW'({$urandom(), $urandom()});
    resp_ready = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    tests_run++;
    if (dut_foo !== 16'h0000 || resp_data !== 16'h0000) begin
      tests_failed++; $display("FAIL reset_data foo=%h resp_data=%h exp 0000", dut_foo, resp_data);
    end
    tests_run++;
    if (resp_valid !== 1'b0 || busy !== 1'b0 || resp_id !== 2'd0) begin
      tests_failed++; $display("FAIL reset_ctrl rv=%b busy=%b id=%0d exp 0", resp_valid, busy, resp_id);
    end
    tests_run++;
    if (req_ready !== 4'b0000) begin
      tests_failed++; $display("FAIL reset_ready got=%b exp=0000", req_ready);
    end
    @(negedge clock);
    req_valid = '0;
    reset     = 1'b1;
    m_ptr     = 0;
  endtask

  task automatic test_single();
    logic [NREQ-1:0] rdy; logic [DUT_W-1:0] foo, rd; logic [IDW-1:0] rid;
    int lat; bit st, idl;
    txn(4'b0001, {30'h2AAAAAAA, 10'h3E8}, 0, rdy, foo, lat, rd, rid, st, idl);
    tests_run++;
    if (rdy !== 4'b0001) begin tests_failed++; $display("FAIL single_ready got=%b exp=0001", rdy); end
    tests_run++;
    if (foo !== 16'h03E8) begin tests_failed++; $display("FAIL single_foo got=%h exp=03e8", foo); end
    tests_run++;
    if (lat !== LATENCY + 1) begin tests_failed++; $display("FAIL single_latency got=%0d exp=%0d", lat, LATENCY + 1); end
    tests_run++;
    if (rd !== 16'hFC17 || rid !== 2'd0) begin
      tests_failed++; $display("FAIL single_resp data=%h id=%0d exp fc17/0", rd, rid);
    end
    tests_run++;
    if (!st || !idl) begin tests_failed++; $display("FAIL single_handshake stable=%0d idle=%0d exp 1/1", st, idl); end
    m_ptr = 1;
  endtask

  task automatic test_data_bounds();
    logic [NREQ-1:0] rdy; logic [DUT_W-1:0] foo, rd; logic [IDW-1:0] rid;
    int lat; bit st, idl;
    txn(4'b0001, {30'h3FFFFFFF, 10'h000}, 1, rdy, foo, lat, rd, rid, st, idl);
    tests_run++;
    if (foo !== 16'h0000 || rd !== 16'hFFFF) begin
      tests_failed++; $display("FAIL pad_zero foo=%h data=%h exp 0000/ffff", foo, rd);
    end
    txn(4'b0001, {30'h00000000, 10'h3FF}, 0, rdy, foo, lat, rd, rid, st, idl);
    tests_run++;
    if (foo !== 16'h03FF || rd !== 16'hFC00) begin
      tests_failed++; $display("FAIL pad_ones foo=%h data=%h exp 03ff/fc00", foo, rd);
    end
    repeat (3) @(negedge clock);
    tests_run++;
    if (dut_foo !== 16'h03FF) begin tests_failed++; $display("FAIL foo_hold_idle got=%h exp=03ff", dut_foo); end
    m_ptr = 1;
  endtask

  task automatic test_wrap();
    logic [NREQ-1:0] rdy; logic [DUT_W-1:0] foo, rd; logic [IDW-1:0] rid;
    int lat; bit st, idl;
    txn(4'b0100, DW'({$urandom(), $urandom()}), 0, rdy, foo, lat, rd, rid, st, idl);
    tests_run++;
    if (rid !== 2'd2) begin tests_failed++; $display("FAIL wrap_setup id=%0d exp=2", rid); end
    txn(4'b0101, DW'({$urandom(), $urandom()}), 0, rdy, foo, lat, rd, rid, st, idl);
    tests_run++;
    if (rdy !== 4'b0001 || rid !== 2'd0) begin
      tests_failed++; $display("FAIL wrap_first ready=%b id=%0d exp 0001/0", rdy, rid);
    end
    txn(4'b0101, DW'({$urandom(), $urandom()}), 0, rdy, foo, lat, rd, rid, st, idl);
    tests_run++;
    if (rdy !== 4'b0100 || rid !== 2'd2) begin
      tests_failed++; $display("FAIL wrap_second ready=%b id=%0d exp 0100/2", rdy, rid);
    end
    m_ptr = 3;
  endtask

  task automatic test_resp_hold();
    logic [NREQ-1:0] rdy; logic [DUT_W-1:0] foo, rd; logic [IDW-1:0] rid;
    logic [DW-1:0] d;
    int lat; bit st, idl;
    d = DW'({$urandom(), $urandom()});
    txn(4'b1000, d, 5, rdy, foo, lat, rd, rid, st, idl);
    tests_run++;
    if (!st) begin tests_failed++; $display("FAIL hold_stable got=0 exp=1"); end
    tests_run++;
    if (!idl) begin tests_failed++; $display("FAIL hold_release_idle got=0 exp=1"); end
    tests_run++;
    if (rd !== DUT_W'(32'hFFFF - model_operand(d, 3)) || rid !== 2'd3) begin
      tests_failed++; $display("FAIL hold_resp data=%h id=%0d exp %h/3", rd, rid, DUT_W'(32'hFFFF - model_operand(d, 3)));
    end
    m_ptr = 0;
  endtask

  task automatic test_random();
    logic [NREQ-1:0] v, rdy; logic [DUT_W-1:0] foo, rd, efoo; logic [IDW-1:0] rid;
    logic [DW-1:0] d;
    int lat, g, hold; bit st, idl;
    for (int it = 0; it < 24; it++) begin
      v    = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      d    = DW'({$urandom(), $urandom()});
      hold = $urandom_range(0, 3);
      g    = model_grant(v, m_ptr);
      efoo = DUT_W'(model_operand(d, g));
      txn(v, d, hold, rdy, foo, lat, rd, rid, st, idl);
      tests_run++;
      if (rdy !== model_onehot(g) || rid !== IDW'(g)) begin
        tests_failed++; $display("FAIL rand_grant it=%0d ready=%b id=%0d exp %b/%0d", it, rdy, rid, model_onehot(g), g);
      end
      tests_run++;
      if (foo !== efoo || rd !== DUT_W'(32'hFFFF - int'(efoo))) begin
        tests_failed++; $display("FAIL rand_data it=%0d foo=%h data=%h exp %h/%h", it, foo, rd, efoo, DUT_W'(32'hFFFF - int'(efoo)));
      end
      tests_run++;
      if (lat !== LATENCY + 1 || !st || !idl) begin
        tests_failed++; $display("FAIL rand_timing it=%0d lat=%0d stable=%0d idle=%0d exp %0d/1/1", it, lat, st, idl, LATENCY + 1);
      end
      m_ptr = (g + 1) % NREQ;
    end
  endtask

  task automatic test_reset_in_wait();
    bit saw_resp;
    @(negedge clock);
    req_valid = 4'b0010;
    req_data  = DW'({$urandom(), $urandom()});
    @(posedge clock);
    #1 req_valid = '0;
    @(negedge clock);
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("FAIL rst_wait_busy got=%b exp=1", busy); end
    reset = 1'b0;
    #1;
    tests_run++;
    if (busy !== 1'b0 || resp_valid !== 1'b0 || dut_foo !== 16'h0000 || resp_data !== 16'h0000 || resp_id !== 2'd0) begin
      tests_failed++;
      $display("FAIL rst_async busy=%b rv=%b foo=%h data=%h id=%0d exp all 0", busy, resp_valid, dut_foo, resp_data, resp_id);
    end
    repeat (3) @(negedge clock);
    reset = 1'b1;
    m_ptr = 0;
    saw_resp = 1'b0;
    repeat (8) begin
      @(negedge clock);
      if (resp_valid !== 1'b0 || busy !== 1'b0) saw_resp = 1'b1;
    end
    tests_run++;
    if (saw_resp) begin tests_failed++; $display("FAIL rst_no_resp got=1 exp=0"); end
    req_valid = 4'b1111;
    #1;
    tests_run++;
    if (req_ready !== 4'b0001) begin tests_failed++; $display("FAIL rst_first_grant got=%b exp=0001", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d;
    int gcyc[$]; int gidx[$]; int rids[$]; logic [DUT_W-1:0] rdat[$];
    bit ok;
    d = DW'({$urandom(), $urandom()});
    resp_ready = 1'b1;
    @(negedge clock);
    req_valid = 4'b1111;
    req_data  = d;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (cyc > 0) @(negedge clock);
      #1;
      if (req_ready !== '0) begin gcyc.push_back(cyc); gidx.push_back(model_grant(req_ready, 0)); end
      if (resp_valid === 1'b1) begin rids.push_back(int'(resp_id)); rdat.push_back(resp_data); end
    end
    req_valid = '0;
    @(negedge clock);
    resp_ready = 1'b0;
    tests_run++;
    ok = (gidx.size() == 5) && (rids.size() == 5);
    for (int i = 0; ok && i < 5; i++) begin
      if (gidx[i] != (m_ptr + i) % NREQ || rids[i] != (m_ptr + i) % NREQ) ok = 1'b0;
      if (rdat[i] !== DUT_W'(32'hFFFF - model_operand(d, (m_ptr + i) % NREQ))) ok = 1'b0;
    end
    if (!ok) begin
      tests_failed++; $display("FAIL b2b_order grants=%0d resps=%0d exp 5 in rr order from %0d", gidx.size(), rids.size(), m_ptr);
    end
    tests_run++;
    ok = (gcyc.size() == 5);
    for (int i = 1; ok && i < 5; i++) if (gcyc[i] - gcyc[i-1] != LATENCY + 2) ok = 1'b0;
    if (!ok) begin
      tests_failed++; $display("FAIL b2b_spacing grants=%0d exp 5 spaced %0d cycles", gcyc.size(), LATENCY + 2);
    end
    m_ptr = (m_ptr + 5) % NREQ;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    m_ptr        = 0;
    test_reset();
    test_single();
    test_data_bounds();
    test_wrap();
    test_resp_hold();
    test_random();
    test_reset_in_wait();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
